mac_feeder: RTL and testbench
=============================

# mac_feeder

Operand sequencer directly upstream of the 16-lane MAC array. It assembles 8-bit activation/weight pairs from a 32-bit word stream into 256-bit vectors, issues one vector per cycle slot to the MAC, and drives the MAC accumulator clear. After a programmed number of vectors it captures the MAC's 28-bit accumulator and returns it on a valid/ready result port. Every MAC accumulation is therefore framed as a single start-to-result transaction.

## Interface
- LEN_W, 8, width of `cfg_len`; maximum 255 vectors per dot product, which cannot overflow the 28-bit accumulator.
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle request to begin a dot product
- cfg_len  in  LEN_W  vectors per dot product; sampled on the accepted `start`
- busy  out  1  high in every state except IDLE
- in_data  in  32  four bytes; byte b maps to bits [8b+7:8b]
- in_valid  in  1  `in_data` valid
- in_ready  out  1  feeder accepts a word
- mac_data  out  256  vector to the MAC array; bytes 2i and 2i+1 are multiplied in lane i
- mac_clr_n  out  1  drives the MAC synchronous active-low reset
- mac_acc  in  28  MAC accumulator output
- res_data  out  28  captured dot-product result
- res_valid  out  1  `res_data` valid
- res_ready  in  1  consumer accepts the result

## Operation
- The nth accepted word of a vector (n = 0..7) fills `mac_data` bits [32n+31:32n]. Word 0 is the lowest.
- States: IDLE, FILL, ISSUE, DRAIN, DONE.
- **IDLE**
  - `mac_clr_n` = 0 and `mac_data` = 0.
  - `start` with `cfg_len` != 0 latches the length, clears the vector count and moves to FILL.
  - `start` with `cfg_len` = 0 is ignored.
- **FILL**
  - `in_ready` = 1 and `mac_data` = 0.
  - A word is accepted on any cycle with `in_valid` and `in_ready` both high.
  - The 8th accepted word moves the block to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mac_data` = the assembled vector and the vector count increments.
  - If count = `cfg_len`, go to DRAIN; otherwise go to FILL.
- **DRAIN** (one cycle)
  - `mac_data` = 0.
  - `mac_acc` now holds the full sum; it is loaded into `res_data` at the end of the cycle.
  - Go to DONE.
- **DONE**
  - `res_valid` = 1 and `mac_clr_n` = 0.
  - `res_valid` and `res_data` hold until `res_ready` is high, then the block returns to IDLE.
- `mac_clr_n` = 1 only in FILL, ISSUE and DRAIN.
- `mac_data` is zero outside ISSUE, so the free-running MAC adds nothing on those cycles.
- `start` is ignored when `busy` is high.
- `in_valid` gaps stall FILL indefinitely with no loss of data.
- Reset (any state, mid-transaction included) gives:
  - state IDLE and all counters 0;
  - `res_valid`, `in_ready` and `busy` = 0;
  - `res_data` and `mac_data` = 0;
  - `mac_clr_n` = 0.
  - Any partially filled vector is discarded.

## Timing
- Cycle 0 is the cycle `start` is accepted. Figures assume `in_valid` is held high continuously.
- Without the prefetch macro:
  - ISSUE for vector k (k = 1..L) occurs in cycle 9k.
  - DRAIN occurs in cycle 9L+1.
  - `res_valid` first rises in cycle 9L+2.
- `in_ready` is 0 in IDLE, ISSUE, DRAIN and DONE.
- With `res_ready` tied high, DONE lasts one cycle and the next `start` is accepted one cycle later, in IDLE.

## Configuration
- Macro: `MAC_FEEDER_PREFETCH_EN`.
- **Defined:** a separate issue register is added, and fill overlaps issue.
  - The cycle after the 8th word of a vector is accepted is that vector's issue cycle, and it also accepts word 0 of the next vector.
  - `in_ready` stays high through issue cycles while vectors remain unfilled.
  - `in_ready` drops once L vectors have been filled.
  - Issue for vector k occurs in cycle 8k+1, DRAIN in cycle 8L+2, and `res_valid` rises in cycle 8L+3.
  - External behaviour is otherwise identical.
- **Undefined:** a single assembly register and the FSM above; throughput is 1 vector per 9 cycles.

## Test plan
- All bytes 0x01, L=1 -> `res_data` = 16; `res_valid` rises in cycle 11, or cycle 11 with the prefetch macro.
- Activations 2, weights 3, L=2 -> `res_data` = 192; `mac_data` is nonzero only in 2 cycles.
- All bytes 0xFF, L=255 -> `res_data` = 265302000, with no overflow.
- `in_valid` toggled every other cycle, L=3, bytes 1 -> `res_data` = 48; word order checked by varying a single lane per vector.
- `res_ready` held low 20 cycles -> `res_valid` and `res_data` remain stable; `start` is ignored during this period.
- Reset pulsed mid-FILL of vector 2 -> all outputs take their reset values. A fresh L=1 run of bytes 1 then gives 16 (no residue from the aborted run). `cfg_len` = 0 with `start` gives `busy` staying 0.

Source files
------------

// File: rtl/mac_feeder_if.sv
// Handshake and bus bundle between mac_feeder, its word source, the MAC array and the result consumer.
interface mac_feeder_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [255:0]     mac_data;
    logic             mac_clr_n;
    logic [27:0]      mac_acc;
    logic [27:0]      res_data;
    logic             res_valid;
    logic             res_ready;

    modport slave (
        input  start, cfg_len, in_data, in_valid, mac_acc, res_ready,
        output busy, in_ready, mac_data, mac_clr_n, res_data, res_valid
    );

    modport master (
        output start, cfg_len, in_data, in_valid, mac_acc, res_ready,
        input  busy, in_ready, mac_data, mac_clr_n, res_data, res_valid
    );
endinterface

// File: rtl/mac_feeder.sv
// Operand sequencer for the 16-lane MAC array: packs 8 words per vector, frames one dot product per start.
// Optional MAC_FEEDER_PREFETCH_EN adds an issue register so filling the next vector overlaps issue.
module mac_feeder #(
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    mac_feeder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FILL, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]      vec_cnt_q, vec_cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [7:0][31:0]      asm_q, asm_d;
    logic [27:0]           res_data_q, res_data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  clr_n_q, clr_n_d;
    logic                  res_valid_q, res_valid_d;
    logic                  accept;
`ifdef MAC_FEEDER_PREFETCH_EN
    logic [255:0]          issue_q, issue_d;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        len_d      = len_q;
        asm_d      = asm_q;
        res_data_d = res_data_q;
`ifdef MAC_FEEDER_PREFETCH_EN
        issue_d    = '0;
`endif
        accept = bus.in_valid && in_ready_q;
        if (accept) begin
            asm_d[word_cnt_q] = bus.in_data;
            word_cnt_d        = word_cnt_q + 3'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.cfg_len != '0) begin
                    len_d      = bus.cfg_len;
                    vec_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (accept && word_cnt_q == 3'd7) begin
`ifdef MAC_FEEDER_PREFETCH_EN
                    // Snapshot the finished vector; the assembly register is free next cycle.
                    issue_d   = asm_d;
                    vec_cnt_d = vec_cnt_q + LEN_W'(1);
                    if (vec_cnt_d == len_q)
                        state_d = ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
`ifdef MAC_FEEDER_PREFETCH_EN
                state_d = DRAIN;
`else
                vec_cnt_d = vec_cnt_q + LEN_W'(1);
                state_d   = (vec_cnt_d == len_q) ? DRAIN : FILL;
`endif
            end
            DRAIN: begin
                // The last issued vector has landed in the accumulator by now.
                res_data_d = bus.mac_acc;
                state_d    = DONE;
            end
            DONE: begin
                if (bus.res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == FILL);
        busy_d      = (state_d != IDLE);
        clr_n_d     = (state_d == FILL) || (state_d == ISSUE) || (state_d == DRAIN);
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            vec_cnt_q   <= '0;
            len_q       <= '0;
            asm_q       <= '0;
            res_data_q  <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            clr_n_q     <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef MAC_FEEDER_PREFETCH_EN
            issue_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            res_data_q  <= res_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            clr_n_q     <= clr_n_d;
            res_valid_q <= res_valid_d;
`ifdef MAC_FEEDER_PREFETCH_EN
            issue_q     <= issue_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.mac_clr_n = clr_n_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
`ifdef MAC_FEEDER_PREFETCH_EN
    assign bus.mac_data  = issue_q;
`else
    assign bus.mac_data  = (state_q == ISSUE) ? asm_q : '0;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: MAC array stand-in, transaction-level reference model checked every cycle, directed runs.
module tb_mac_feeder;
`ifdef MAC_FEEDER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_feeder_if #(.LEN_W(8)) bus ();
    mac_feeder #(.LEN_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [27:0] dot(input logic [255:0] v);
        logic [27:0] s;
        s = '0;
        for (int i = 0; i < 16; i++)
            s += 28'(v[16*i +: 8]) * 28'(v[16*i+8 +: 8]);
        return s;
    endfunction

    // MAC array stand-in: free-running accumulate with synchronous active-low clear.
    logic [27:0] mac_acc_r = '0;
    always @(posedge clk) mac_acc_r <= bus.mac_clr_n ? mac_acc_r + dot(bus.mac_data) : 28'd0;
    assign bus.mac_acc = mac_acc_r;

    // Reference model: one transaction from accepted start to result handshake.
    bit           m_on = 0, m_act = 0, m_done = 0, m_issue = 0, m_drain = 0, m_rst_prev = 0;
    int           m_len = 0, m_filled = 0, m_wcnt = 0, m_issued = 0;
    logic [255:0] m_asm = '0, m_ivec = '0;
    logic [27:0]  m_sum = '0;
    int           cyc = 0, start_cyc = 0, rise_cyc = -1, res_cnt = 0, mac_nz = 0;
    logic [27:0]  last_res = '0;
    bit           prev_rv = 0;

    always @(negedge clk) begin
        bit ir_e, nxt_issue, nxt_drain;
        ir_e = 1'b0;
        cyc++;
        if (m_on) begin
            ir_e = m_act && !m_done && (m_filled < m_len) && !(m_issue && !PF);
            chk("busy", bus.busy, m_act);
            chk("in_ready", bus.in_ready, ir_e);
            chk("mac_clr_n", bus.mac_clr_n, m_act && !m_done);
            chk("mac_data", bus.mac_data, m_issue ? m_ivec : 256'd0);
            chk("res_valid", bus.res_valid, m_done);
            if (m_done)     chk("res_data", bus.res_data, m_sum);
            if (m_rst_prev) chk("res_data_rst", bus.res_data, 0);
        end
        if (bus.mac_data != '0) mac_nz++;
        if (bus.res_valid === 1'b1 && !prev_rv) rise_cyc = cyc - start_cyc;
        prev_rv = (bus.res_valid === 1'b1);

        if (!reset) begin
            m_on = 1; m_act = 0; m_done = 0; m_issue = 0; m_drain = 0; m_rst_prev = 1;
        end else begin
            m_rst_prev = 0;
            nxt_issue  = 0;
            nxt_drain  = 0;
            if (!m_act) begin
                if (bus.start && bus.cfg_len != 0) begin
                    m_act = 1; m_len = int'(bus.cfg_len); m_filled = 0; m_wcnt = 0;
                    m_issued = 0; m_sum = '0; start_cyc = cyc;
                end
            end else if (m_done) begin
                if (bus.res_ready) begin
                    m_act = 0; m_done = 0; res_cnt++; last_res = bus.res_data;
                end
            end else begin
                if (m_drain) m_done = 1;
                if (m_issue) begin
                    m_sum += dot(m_ivec);
                    m_issued++;
                    if (m_issued == m_len) nxt_drain = 1;
                end
                if (ir_e && bus.in_valid) begin
                    m_asm[32*m_wcnt +: 32] = bus.in_data;
                    m_wcnt++;
                    if (m_wcnt == 8) begin
                        m_wcnt = 0; m_filled++; nxt_issue = 1;
                    end
                end
            end
            if (nxt_issue) m_ivec = m_asm;
            m_issue = nxt_issue;
            m_drain = nxt_drain;
        end
    end

    logic [31:0] wq[$];

    task automatic fill(input int n, input logic [31:0] w);
        for (int i = 0; i < n; i++) wq.push_back(w);
    endtask

    // Present queued words; gap=1 drops in_valid every other cycle. Stops after max_n accepted.
    task automatic send_words(input bit gap, input int max_n);
        int n = 0, sent = 0, wait_c = 0;
        bit acc;
        while (wq.size() > 0 && sent < max_n) begin
            if (gap && n[0]) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = wq[0];
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            n++;
            if (acc) begin
                void'(wq.pop_front());
                sent++;
                wait_c = 0;
            end else if (++wait_c > 100) begin
                chk("word_accept_timeout", 0, 1);
                wq.delete();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input int len);
        bus.start   = 1'b1;
        bus.cfg_len = 8'(len);
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_result();
        int r0 = res_cnt, t = 0;
        while (res_cnt == r0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (res_cnt == r0) chk("result_timeout", 0, 1);
    endtask

    task automatic run(input int len, input bit gap);
        do_start(len);
        send_words(gap, 1 << 30);
        wait_result();
    endtask

    initial begin
        bus.start = 0; bus.cfg_len = '0; bus.in_valid = 0; bus.in_data = '0; bus.res_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_clr_n", bus.mac_clr_n, 0);
        @(posedge clk); #1;

        // L=1, all ones: 16 lanes of 1*1
        fill(8, 32'h01010101);
        run(1, 0);
        chk("ones_l1_result", last_res, 16);
        chk("ones_l1_rise", rise_cyc, 11);

        // Activations 2, weights 3, L=2: 2*16*6
        mac_nz = 0;
        fill(16, 32'h03020302);
        run(2, 0);
        chk("act2_wt3_result", last_res, 192);
        chk("act2_wt3_issue_cycles", mac_nz, 2);
        chk("act2_wt3_rise", rise_cyc, PF ? 19 : 20);

        // Full-scale bytes, longest dot product
        fill(8 * 255, 32'hFFFFFFFF);
        run(255, 0);
        chk("ff_l255_result", last_res, 265302000);

        // in_valid toggling, L=3
        fill(24, 32'h01010101);
        run(3, 1);
        chk("gap_l3_result", last_res, 48);

        // One lane raised to 5 per vector: lane 0, lane 1, lane 2
        wq.push_back(32'h01010105); fill(7, 32'h01010101);
        wq.push_back(32'h01050101); fill(7, 32'h01010101);
        fill(1, 32'h01010101); wq.push_back(32'h01010105); fill(6, 32'h01010101);
        run(3, 1);
        chk("lane_walk_result", last_res, 60);

        // Result held under backpressure; start attempts ignored
        bus.res_ready = 1'b0;
        fill(8, 32'h02020202);
        do_start(1);
        send_words(0, 8);
        for (int t = 0; t < 50 && bus.res_valid !== 1'b1; t++) begin
            @(posedge clk); #1;
        end
        for (int t = 0; t < 20; t++) begin
            bus.start   = t[1];
            bus.cfg_len = 8'd5;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("hold_busy", bus.busy, 1);
        chk("hold_res_data", bus.res_data, 64);
        bus.res_ready = 1'b1;
        wait_result();
        chk("hold_result", last_res, 64);

        // Reset during vector 2 fill
        fill(16, 32'h01010101);
        do_start(2);
        send_words(0, 11);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wq.delete();
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_res_data", bus.res_data, 0);
        chk("abort_mac_data", bus.mac_data, 0);
        chk("abort_clr_n", bus.mac_clr_n, 0);
        @(posedge clk); #1;
        fill(8, 32'h01010101);
        run(1, 0);
        chk("after_abort_result", last_res, 16);

        // Zero length start is ignored
        do_start(0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("zero_len_busy", bus.busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
